// File: rtl/ahb_router_if.sv
// AHB-Lite bus bundle seen by the router: the master's address/control and
// response signals plus the packed per-slave select and response vectors.
interface ahb_router_if #(
  parameter int slave_c = 4
) ();

  logic [31:0]           haddr_m;
  logic [1:0]            htrans_m;
  logic                  hwrite_m;
  logic [31:0]           hrdata_m;
  logic [1:0]            hresp_m;
  logic                  hready_m;
  logic [slave_c-1:0]    hsel_s;
  logic [32*slave_c-1:0] hrdata_s;
  logic [2*slave_c-1:0]  hresp_s;
  logic [slave_c-1:0]    hready_s;

  // Router view: consumes the master request and slave responses.
  modport slave (
    input  haddr_m, htrans_m, hwrite_m, hrdata_s, hresp_s, hready_s,
    output hrdata_m, hresp_m, hready_m, hsel_s
  );

  // Environment view: master and slaves driving the router.
  modport master (
    output haddr_m, htrans_m, hwrite_m, hrdata_s, hresp_s, hready_s,
    input  hrdata_m, hresp_m, hready_m, hsel_s
  );

endinterface

// File: rtl/ahb_router.sv
// AHB-Lite address decoder and response multiplexer. Decodes haddr[31:28]
// into a one-hot slave select, remembers which slave owns the data phase and
// returns that slave's response. Unmapped regions hit an internal default
// slave that answers with a two-cycle ERROR response.
module ahb_router #(
  parameter int slave_c = 4
) (
  input  logic          hclk,
  input  logic          hresetn,
  ahb_router_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_NONE  = 2'b00,
    ST_SLAVE = 2'b01,
    ST_ERR1  = 2'b10,
    ST_ERR2  = 2'b11
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_e             state_q, state_d;
  logic [3:0]         own_q, own_d;

  logic [3:0]         idx;
  logic               request;
  logic               mapped;
  logic               hready;
  logic [1:0]         hresp;
  logic [31:0]        hrdata;
  logic               own_ready;
  logic [1:0]         own_resp;
  logic [31:0]        own_rdata;
  logic [slave_c-1:0] hsel;
  logic               unused_bits;

  assign idx     = bus.haddr_m[31:28];
  assign request = bus.htrans_m[1];
  assign mapped  = ({1'b0, idx} < 5'(slave_c));

  // Low address bits, HTRANS[0] and HWRITE reach the slaves directly.
  assign unused_bits = ^{bus.haddr_m[27:0], bus.htrans_m[0], bus.hwrite_m};

  // Pick the owning slave's response lanes (own_q is always < slave_c).
  always_comb begin
    own_ready = 1'b1;
    own_resp  = RESP_OKAY;
    own_rdata = 32'h0000_0000;
    for (int i = 0; i < slave_c; i++) begin
      own_ready = (own_q == 4'(i)) ? bus.hready_s[i]        : own_ready;
      own_resp  = (own_q == 4'(i)) ? bus.hresp_s[2*i +: 2]  : own_resp;
      own_rdata = (own_q == 4'(i)) ? bus.hrdata_s[32*i +: 32] : own_rdata;
    end
  end

  // Response mux driven purely by the data-phase state.
  always_comb begin
    hready = 1'b1;
    hresp  = RESP_OKAY;
    hrdata = 32'h0000_0000;
    case (state_q)
      ST_NONE: begin
        hready = 1'b1;
        hresp  = RESP_OKAY;
        hrdata = 32'h0000_0000;
      end
      ST_SLAVE: begin
        hready = own_ready;
        hresp  = own_resp;
        hrdata = own_rdata;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = RESP_ERROR;
        hrdata = 32'h0000_0000;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = RESP_ERROR;
        hrdata = 32'h0000_0000;
      end
      default: begin
        hready = 1'b1;
        hresp  = RESP_OKAY;
        hrdata = 32'h0000_0000;
      end
    endcase
  end

  // One-hot select only in the cycle an address phase is accepted.
  always_comb begin
    hsel = '0;
    for (int i = 0; i < slave_c; i++) begin
      hsel[i] = request && mapped && (idx == 4'(i)) && hready && hresetn;
    end
  end

  assign bus.hready_m = hready;
  assign bus.hresp_m  = hresp;
  assign bus.hrdata_m = hrdata;
  assign bus.hsel_s   = hsel;

  // Data-phase ownership: a new phase starts whenever the bus is ready,
  // except ERR1 which always advances to ERR2 and ignores the bus.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_NONE, ST_SLAVE, ST_ERR2: begin
        if (hready) begin
          if (request && mapped) begin
            state_d = ST_SLAVE;
            own_d   = idx;
          end else if (request) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_NONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_NONE;
        own_d   = 4'd0;
      end
    endcase
  end

  // State and owner registers, cleared asynchronously.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_NONE;
      own_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

endmodule

// File: tb/tb_ahb_router.sv
// Self-checking bench for ahb_router: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the router.
module tb_ahb_router;

  localparam int NS = 4;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic hclk = 1'b0;
  logic hresetn;

  always #5 hclk = ~hclk;

  ahb_router_if #(.slave_c(NS)) bus ();

  ahb_router #(.slave_c(NS)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the data phase: which slave owns it (-1 = none) and how many
  // default-slave ERROR cycles are still outstanding.
  int m_owner    = -1;
  int m_err_left = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of bus inputs, check the router, then advance the model.
  task automatic step(input logic [31:0] addr, input logic [1:0] trans,
                      input logic [NS-1:0] rdys, input logic [2*NS-1:0] resps,
                      input logic [32*NS-1:0] rdatas, input logic rst);
    logic        exp_ready;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [NS-1:0] exp_sel;
    int          idx;
    bit          acc;
    bus.haddr_m  = addr;
    bus.htrans_m = trans;
    bus.hwrite_m = 1'($urandom);
    bus.hready_s = rdys;
    bus.hresp_s  = resps;
    bus.hrdata_s = rdatas;
    hresetn      = rst;
    if (!rst) begin
      m_owner    = -1;
      m_err_left = 0;
    end
    #3;
    idx = int'(addr[31:28]);
    if (m_err_left == 2) begin
      exp_ready = 1'b0; exp_resp = 2'b01; exp_rdata = 32'h0;
    end else if (m_err_left == 1) begin
      exp_ready = 1'b1; exp_resp = 2'b01; exp_rdata = 32'h0;
    end else if (m_owner >= 0) begin
      exp_ready = rdys[m_owner];
      exp_resp  = resps[2*m_owner +: 2];
      exp_rdata = rdatas[32*m_owner +: 32];
    end else begin
      exp_ready = 1'b1; exp_resp = 2'b00; exp_rdata = 32'h0;
    end
    acc = trans[1] && exp_ready && rst;
    exp_sel = '0;
    if (acc && idx < NS) exp_sel[idx] = 1'b1;
    check_eq("hsel_s",   128'(bus.hsel_s),   128'(exp_sel));
    check_eq("hready_m", 128'(bus.hready_m), 128'(exp_ready));
    check_eq("hresp_m",  128'(bus.hresp_m),  128'(exp_resp));
    check_eq("hrdata_m", 128'(bus.hrdata_m), 128'(exp_rdata));
    if (!rst) begin
      m_owner = -1; m_err_left = 0;
    end else if (m_err_left == 2) begin
      m_err_left = 1;
    end else if (exp_ready) begin
      if (acc && idx < NS) begin
        m_owner = idx; m_err_left = 0;
      end else if (acc) begin
        m_owner = -1; m_err_left = 2;
      end else begin
        m_owner = -1; m_err_left = 0;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  logic [32*NS-1:0] d;
  logic [32*NS-1:0] rd;
  logic [NS-1:0]    rr;

  initial begin
    d = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h0000_00A5};
    hresetn      = 1'b0;
    bus.haddr_m  = 32'h0;
    bus.htrans_m = IDLE;
    bus.hwrite_m = 1'b0;
    bus.hready_s = '1;
    bus.hresp_s  = '0;
    bus.hrdata_s = d;
    @(posedge hclk);
    #1;

    // Reset holds selects off even with a request on the bus.
    step(32'h1000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b0);
    step(32'h1000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b0);

    // Write to slave 1, then its data phase with wait and ERROR pass-through.
    step(32'h1000_0004, NONSEQ, 4'hF,    8'h00,        d, 1'b1);
    step(32'h0000_0000, IDLE,   4'b1101, 8'b0000_0100, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'b0010, 8'b0000_0100, d, 1'b1);

    // Read slave 0 with a two-cycle stall while NONSEQ is held.
    step(32'h0000_0000, NONSEQ, 4'hF,    8'h00, d, 1'b1);
    step(32'h0000_0000, NONSEQ, 4'b1110, 8'h00, d, 1'b1);
    step(32'h0000_0000, NONSEQ, 4'b1110, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF,    8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF,    8'h00, d, 1'b1);

    // Unmapped access: ERR1, ERR2, then idle.
    step(32'h5000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);

    // Pipelined reads of slave 2 then slave 0.
    step(32'h2000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0010, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);

    // Back-to-back unmapped; the address offered during ERR1 is ignored.
    step(32'h5000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h1000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h7000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);

    // Reset during ERR1, then a normal access to slave 3.
    step(32'h5000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b0);
    step(32'h3000_0000, NONSEQ, 4'hF, 8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'hF, 8'h00, d, 1'b1);

    // Reset during a slave stall.
    step(32'h1000_0000, NONSEQ, 4'hF,    8'h00, d, 1'b1);
    step(32'h0000_0000, IDLE,   4'b1101, 8'h00, d, 1'b0);
    step(32'h0000_0000, IDLE,   4'hF,    8'h00, d, 1'b1);

    // Random traffic over mapped and unmapped regions.
    for (int n = 0; n < 3000; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NS; i++) rr[i] = ($urandom_range(0, 3) != 0);
      step({4'($urandom_range(0, 7)), 28'($urandom)}, 2'($urandom), rr,
           8'($urandom) & 8'h55, rd, ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_router.md
# ahb_router

AHB-Lite address decoder and response multiplexer between the single AHB master and up to 16 slaves such as the GPIO slave. It decodes each address phase into a one-hot `hsel_s` and tracks which slave owns the current data phase. It then returns that slave's HRDATA, HRESP and HREADYOUT to the master. Transfers to unmapped regions go to an internal default slave that answers with a two-cycle ERROR response.

## Interface
- `slave_c`, 4: number of attached slaves, 1..16. Slave i owns region `haddr[31:28] == i`.
- `hclk`  in  1  bus clock, all state on rising edge
- `hresetn`  in  1  reset, asynchronous, active-low
- `haddr_m`  in  32  master HADDR
- `htrans_m`  in  2  master HTRANS
- `hwrite_m`  in  1  master HWRITE (not decoded; passes to slaves on the shared bus)
- `hrdata_m`  out  32  HRDATA to master
- `hresp_m`  out  2  HRESP to master (OKAY = 2'b00, ERROR = 2'b01)
- `hready_m`  out  1  HREADY to master and to all slaves' view of the bus
- `hsel_s`  out  slave_c  one-hot slave select
- `hrdata_s`  in  32*slave_c  packed slave HRDATA, slave i at [32*i+31 : 32*i]
- `hresp_s`  in  2*slave_c  packed slave HRESP
- `hready_s`  in  slave_c  slave HREADYOUT. Only meaningful while that slave owns the data phase.

## Operation
- Transfer request: `htrans_m[1] == 1` (NONSEQ/SEQ). IDLE and BUSY are not requests.
- Decode: `idx = haddr_m[31:28]`. Mapped if `idx < slave_c`.
- `hsel_s[i] = request && mapped && idx == i && hready_m && hresetn`. This is combinational. Slaves therefore see an address phase only in the cycle it is accepted, and never during a stall.
- Data-phase FSM. States are NONE, SLAVE (with registered owner index `own`), ERR1 and ERR2.
  - In NONE, SLAVE or ERR2, when `hready_m == 1` at the clock edge:
    - request and mapped: go to SLAVE with `own <= idx`
    - request and unmapped: go to ERR1
    - otherwise: go to NONE
  - In SLAVE with `hready_m == 0`: hold state and `own`.
  - ERR1 always goes to ERR2.
- Output mux, all combinational from state:
  - NONE: `hready_m=1`, `hresp_m=OKAY`, `hrdata_m=0`
  - SLAVE: `hready_m=hready_s[own]`, `hresp_m=hresp_s[own]`, `hrdata_m=hrdata_s[own]`
  - ERR1: `hready_m=0`, `hresp_m=ERROR`, `hrdata_m=0`
  - ERR2: `hready_m=1`, `hresp_m=ERROR`, `hrdata_m=0`
- Slave ERROR responses pass through unchanged. The router adds no extra cycle.
- Master address changes during ERR1 are ignored. The next address is accepted in ERR2.

## Timing
- Reset (async assert, sync release): state NONE, `own=0`.
  - Outputs while reset is low: `hready_m=1`, `hresp_m=00`, `hrdata_m=0`, `hsel_s=0`.
- The router adds zero latency to the slave path. The data phase begins the cycle after address acceptance.
- Pipelining: a new address phase may be accepted in the same cycle that the previous data phase completes (`hready_m=1`). The owner switches on that edge with no bubble.
- Default-slave transfer: exactly 2 data-phase cycles (ERR1 then ERR2).
- Back-to-back unmapped transfers: ERR2 goes to ERR1 if another unmapped request is accepted in ERR2.
- Reset asserted mid-stall (SLAVE with `hready_s` low, or ERR1): the FSM returns to NONE immediately and outputs take their reset values in the same cycle.
- A `hready_s[i]` value from a slave that does not own the data phase has no effect.

## Test plan
- Reset with `slave_c=4`: hold `hresetn` low, drive `htrans_m=NONSEQ`, `haddr_m=0x1000_0000` -> `hsel_s=0`, `hready_m=1`, `hresp_m=00`, `hrdata_m=0`.
- Write NONSEQ to 0x1000_0004 -> `hsel_s=4'b0010` in the address cycle. Next cycle `hready_m` follows `hready_s[1]`, and `hresp_m=hresp_s[3:2]`.
- Read slave 0 at 0x0000_0000 with `hready_s[0]` low for 2 cycles, then high with `hrdata_s[31:0]=0x0000_00A5`:
  - `hready_m=0` for 2 cycles, then 1 with `hrdata_m=0xA5`.
  - `hsel_s` stays 0 during the stall even with NONSEQ held on the bus.
- NONSEQ to 0x5000_0000 -> no `hsel_s` bit set. Next cycle `hready_m=0`, `hresp_m=01`. Following cycle `hready_m=1`, `hresp_m=01`. Then NONE: `hready_m=1`, `hresp_m=00`.
- Pipelined reads: slave 2 (0x2000_0000), then slave 0 (0x0000_0010), then IDLE, with distinct `hrdata_s` values -> `hsel_s` is 0100 then 0001 on consecutive cycles, and `hrdata_m` returns slave 2 data then slave 0 data on consecutive cycles.
- Assert `hresetn` during ERR1 -> `hready_m=1` and `hresp_m=00` in the same cycle. After release, a NONSEQ to 0x3000_0000 selects `hsel_s=4'b1000` normally.
